// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the AES decryption datapath.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Byte ordering used throughout: byte s[k] = state[127-8k -: 8] and
// s[r+4c] is row r, column c (column-major, FIPS-197).
package aes_dec_pkg;

   localparam int AES_STATE_W   = 128;
   localparam int AES_BYTE_W    = 8;
   localparam int AES_NUM_BYTES = 16;

   typedef logic [AES_STATE_W-1:0] aes_state_t;
   typedef logic [AES_BYTE_W-1:0]  aes_byte_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } inv_sb_state_e;

   // InvShiftRows: row r rotates right by r, i.e. out[r+4c] = in[r+4((c-r) mod 4)].
   function automatic aes_state_t inv_shift_rows(input aes_state_t s);
      aes_state_t o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[AES_STATE_W-1-AES_BYTE_W*(r+4*c) -: AES_BYTE_W] =
               s[AES_STATE_W-1-AES_BYTE_W*(r+4*((c-r+4)%4)) -: AES_BYTE_W];
         end
      end
      return o;
   endfunction

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box, one byte, exact FIPS-197 inverse table.
// Latency: combinational.
// Backpressure: none (pure lookup).
//
// Ports: sbox_in (8) byte to substitute; sbox_out (8) InvSbox(sbox_in).
module inv_sbox (
   input  logic [7:0] sbox_in,
   output logic [7:0] sbox_out
);

   always_comb begin
      sbox_out = 8'h00;
      case (sbox_in)
         8'h00: sbox_out = 8'h52; 8'h01: sbox_out = 8'h09; 8'h02: sbox_out = 8'h6a; 8'h03: sbox_out = 8'hd5; 8'h04: sbox_out = 8'h30; 8'h05: sbox_out = 8'h36; 8'h06: sbox_out = 8'ha5; 8'h07: sbox_out = 8'h38;
         8'h08: sbox_out = 8'hbf; 8'h09: sbox_out = 8'h40; 8'h0a: sbox_out = 8'ha3; 8'h0b: sbox_out = 8'h9e; 8'h0c: sbox_out = 8'h81; 8'h0d: sbox_out = 8'hf3; 8'h0e: sbox_out = 8'hd7; 8'h0f: sbox_out = 8'hfb;
         8'h10: sbox_out = 8'h7c; 8'h11: sbox_out = 8'he3; 8'h12: sbox_out = 8'h39; 8'h13: sbox_out = 8'h82; 8'h14: sbox_out = 8'h9b; 8'h15: sbox_out = 8'h2f; 8'h16: sbox_out = 8'hff; 8'h17: sbox_out = 8'h87;
         8'h18: sbox_out = 8'h34; 8'h19: sbox_out = 8'h8e; 8'h1a: sbox_out = 8'h43; 8'h1b: sbox_out = 8'h44; 8'h1c: sbox_out = 8'hc4; 8'h1d: sbox_out = 8'hde; 8'h1e: sbox_out = 8'he9; 8'h1f: sbox_out = 8'hcb;
         8'h20: sbox_out = 8'h54; 8'h21: sbox_out = 8'h7b; 8'h22: sbox_out = 8'h94; 8'h23: sbox_out = 8'h32; 8'h24: sbox_out = 8'ha6; 8'h25: sbox_out = 8'hc2; 8'h26: sbox_out = 8'h23; 8'h27: sbox_out = 8'h3d;
         8'h28: sbox_out = 8'hee; 8'h29: sbox_out = 8'h4c; 8'h2a: sbox_out = 8'h95; 8'h2b: sbox_out = 8'h0b; 8'h2c: sbox_out = 8'h42; 8'h2d: sbox_out = 8'hfa; 8'h2e: sbox_out = 8'hc3; 8'h2f: sbox_out = 8'h4e;
         8'h30: sbox_out = 8'h08; 8'h31: sbox_out = 8'h2e; 8'h32: sbox_out = 8'ha1; 8'h33: sbox_out = 8'h66; 8'h34: sbox_out = 8'h28; 8'h35: sbox_out = 8'hd9; 8'h36: sbox_out = 8'h24; 8'h37: sbox_out = 8'hb2;
         8'h38: sbox_out = 8'h76; 8'h39: sbox_out = 8'h5b; 8'h3a: sbox_out = 8'ha2; 8'h3b: sbox_out = 8'h49; 8'h3c: sbox_out = 8'h6d; 8'h3d: sbox_out = 8'h8b; 8'h3e: sbox_out = 8'hd1; 8'h3f: sbox_out = 8'h25;
         8'h40: sbox_out = 8'h72; 8'h41: sbox_out = 8'hf8; 8'h42: sbox_out = 8'hf6; 8'h43: sbox_out = 8'h64; 8'h44: sbox_out = 8'h86; 8'h45: sbox_out = 8'h68; 8'h46: sbox_out = 8'h98; 8'h47: sbox_out = 8'h16;
         8'h48: sbox_out = 8'hd4; 8'h49: sbox_out = 8'ha4; 8'h4a: sbox_out = 8'h5c; 8'h4b: sbox_out = 8'hcc; 8'h4c: sbox_out = 8'h5d; 8'h4d: sbox_out = 8'h65; 8'h4e: sbox_out = 8'hb6; 8'h4f: sbox_out = 8'h92;
         8'h50: sbox_out = 8'h6c; 8'h51: sbox_out = 8'h70; 8'h52: sbox_out = 8'h48; 8'h53: sbox_out = 8'h50; 8'h54: sbox_out = 8'hfd; 8'h55: sbox_out = 8'hed; 8'h56: sbox_out = 8'hb9; 8'h57: sbox_out = 8'hda;
         8'h58: sbox_out = 8'h5e; 8'h59: sbox_out = 8'h15; 8'h5a: sbox_out = 8'h46; 8'h5b: sbox_out = 8'h57; 8'h5c: sbox_out = 8'ha7; 8'h5d: sbox_out = 8'h8d; 8'h5e: sbox_out = 8'h9d; 8'h5f: sbox_out = 8'h84;
         8'h60: sbox_out = 8'h90; 8'h61: sbox_out = 8'hd8; 8'h62: sbox_out = 8'hab; 8'h63: sbox_out = 8'h00; 8'h64: sbox_out = 8'h8c; 8'h65: sbox_out = 8'hbc; 8'h66: sbox_out = 8'hd3; 8'h67: sbox_out = 8'h0a;
         8'h68: sbox_out = 8'hf7; 8'h69: sbox_out = 8'he4; 8'h6a: sbox_out = 8'h58; 8'h6b: sbox_out = 8'h05; 8'h6c: sbox_out = 8'hb8; 8'h6d: sbox_out = 8'hb3; 8'h6e: sbox_out = 8'h45; 8'h6f: sbox_out = 8'h06;
         8'h70: sbox_out = 8'hd0; 8'h71: sbox_out = 8'h2c; 8'h72: sbox_out = 8'h1e; 8'h73: sbox_out = 8'h8f; 8'h74: sbox_out = 8'hca; 8'h75: sbox_out = 8'h3f; 8'h76: sbox_out = 8'h0f; 8'h77: sbox_out = 8'h02;
         8'h78: sbox_out = 8'hc1; 8'h79: sbox_out = 8'haf; 8'h7a: sbox_out = 8'hbd; 8'h7b: sbox_out = 8'h03; 8'h7c: sbox_out = 8'h01; 8'h7d: sbox_out = 8'h13; 8'h7e: sbox_out = 8'h8a; 8'h7f: sbox_out = 8'h6b;
         8'h80: sbox_out = 8'h3a; 8'h81: sbox_out = 8'h91; 8'h82: sbox_out = 8'h11; 8'h83: sbox_out = 8'h41; 8'h84: sbox_out = 8'h4f; 8'h85: sbox_out = 8'h67; 8'h86: sbox_out = 8'hdc; 8'h87: sbox_out = 8'hea;
         8'h88: sbox_out = 8'h97; 8'h89: sbox_out = 8'hf2; 8'h8a: sbox_out = 8'hcf; 8'h8b: sbox_out = 8'hce; 8'h8c: sbox_out = 8'hf0; 8'h8d: sbox_out = 8'hb4; 8'h8e: sbox_out = 8'he6; 8'h8f: sbox_out = 8'h73;
         8'h90: sbox_out = 8'h96; 8'h91: sbox_out = 8'hac; 8'h92: sbox_out = 8'h74; 8'h93: sbox_out = 8'h22; 8'h94: sbox_out = 8'he7; 8'h95: sbox_out = 8'had; 8'h96: sbox_out = 8'h35; 8'h97: sbox_out = 8'h85;
         8'h98: sbox_out = 8'he2; 8'h99: sbox_out = 8'hf9; 8'h9a: sbox_out = 8'h37; 8'h9b: sbox_out = 8'he8; 8'h9c: sbox_out = 8'h1c; 8'h9d: sbox_out = 8'h75; 8'h9e: sbox_out = 8'hdf; 8'h9f: sbox_out = 8'h6e;
         8'ha0: sbox_out = 8'h47; 8'ha1: sbox_out = 8'hf1; 8'ha2: sbox_out = 8'h1a; 8'ha3: sbox_out = 8'h71; 8'ha4: sbox_out = 8'h1d; 8'ha5: sbox_out = 8'h29; 8'ha6: sbox_out = 8'hc5; 8'ha7: sbox_out = 8'h89;
         8'ha8: sbox_out = 8'h6f; 8'ha9: sbox_out = 8'hb7; 8'haa: sbox_out = 8'h62; 8'hab: sbox_out = 8'h0e; 8'hac: sbox_out = 8'haa; 8'had: sbox_out = 8'h18; 8'hae: sbox_out = 8'hbe; 8'haf: sbox_out = 8'h1b;
         8'hb0: sbox_out = 8'hfc; 8'hb1: sbox_out = 8'h56; 8'hb2: sbox_out = 8'h3e; 8'hb3: sbox_out = 8'h4b; 8'hb4: sbox_out = 8'hc6; 8'hb5: sbox_out = 8'hd2; 8'hb6: sbox_out = 8'h79; 8'hb7: sbox_out = 8'h20;
         8'hb8: sbox_out = 8'h9a; 8'hb9: sbox_out = 8'hdb; 8'hba: sbox_out = 8'hc0; 8'hbb: sbox_out = 8'hfe; 8'hbc: sbox_out = 8'h78; 8'hbd: sbox_out = 8'hcd; 8'hbe: sbox_out = 8'h5a; 8'hbf: sbox_out = 8'hf4;
         8'hc0: sbox_out = 8'h1f; 8'hc1: sbox_out = 8'hdd; 8'hc2: sbox_out = 8'ha8; 8'hc3: sbox_out = 8'h33; 8'hc4: sbox_out = 8'h88; 8'hc5: sbox_out = 8'h07; 8'hc6: sbox_out = 8'hc7; 8'hc7: sbox_out = 8'h31;
         8'hc8: sbox_out = 8'hb1; 8'hc9: sbox_out = 8'h12; 8'hca: sbox_out = 8'h10; 8'hcb: sbox_out = 8'h59; 8'hcc: sbox_out = 8'h27; 8'hcd: sbox_out = 8'h80; 8'hce: sbox_out = 8'hec; 8'hcf: sbox_out = 8'h5f;
         8'hd0: sbox_out = 8'h60; 8'hd1: sbox_out = 8'h51; 8'hd2: sbox_out = 8'h7f; 8'hd3: sbox_out = 8'ha9; 8'hd4: sbox_out = 8'h19; 8'hd5: sbox_out = 8'hb5; 8'hd6: sbox_out = 8'h4a; 8'hd7: sbox_out = 8'h0d;
         8'hd8: sbox_out = 8'h2d; 8'hd9: sbox_out = 8'he5; 8'hda: sbox_out = 8'h7a; 8'hdb: sbox_out = 8'h9f; 8'hdc: sbox_out = 8'h93; 8'hdd: sbox_out = 8'hc9; 8'hde: sbox_out = 8'h9c; 8'hdf: sbox_out = 8'hef;
         8'he0: sbox_out = 8'ha0; 8'he1: sbox_out = 8'he0; 8'he2: sbox_out = 8'h3b; 8'he3: sbox_out = 8'h4d; 8'he4: sbox_out = 8'hae; 8'he5: sbox_out = 8'h2a; 8'he6: sbox_out = 8'hf5; 8'he7: sbox_out = 8'hb0;
         8'he8: sbox_out = 8'hc8; 8'he9: sbox_out = 8'heb; 8'hea: sbox_out = 8'hbb; 8'heb: sbox_out = 8'h3c; 8'hec: sbox_out = 8'h83; 8'hed: sbox_out = 8'h53; 8'hee: sbox_out = 8'h99; 8'hef: sbox_out = 8'h61;
         8'hf0: sbox_out = 8'h17; 8'hf1: sbox_out = 8'h2b; 8'hf2: sbox_out = 8'h04; 8'hf3: sbox_out = 8'h7e; 8'hf4: sbox_out = 8'hba; 8'hf5: sbox_out = 8'h77; 8'hf6: sbox_out = 8'hd6; 8'hf7: sbox_out = 8'h26;
         8'hf8: sbox_out = 8'he1; 8'hf9: sbox_out = 8'h69; 8'hfa: sbox_out = 8'h14; 8'hfb: sbox_out = 8'h63; 8'hfc: sbox_out = 8'h55; 8'hfd: sbox_out = 8'h21; 8'hfe: sbox_out = 8'h0c; 8'hff: sbox_out = 8'h7d;
      endcase
   end

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Byte-serial AES InvSubBytes: BYTES_PER_CYCLE bytes substituted per clock.
// Latency: accept edge to first out_valid cycle = NUM_STEPS+1 clocks; one word per NUM_STEPS+2 clocks.
// Backpressure: in_ready low outside IDLE; result held stable in DONE until out_ready.
//
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_state (128) input word;
//        out_valid/out_ready/out_state (128) result; busy high outside IDLE.
// Build option: INV_SUB_BYTES_SHIFT_EN folds InvShiftRows into the final write.
module inv_sub_bytes_seq
   import aes_dec_pkg::*;
#(
   parameter int BYTES_PER_CYCLE = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [AES_STATE_W-1:0] in_state,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [AES_STATE_W-1:0] out_state,
   output logic                   busy
);

   localparam int NUM_STEPS = AES_NUM_BYTES / BYTES_PER_CYCLE;
   localparam int STEP_W    = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_STEPS - 1);

   if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
         BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
      $fatal(1, "inv_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
   end

   inv_sb_state_e state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   aes_state_t work_q, work_d;
   aes_state_t sub_state;

   aes_byte_t work_b [AES_NUM_BYTES];
   aes_byte_t sub_b  [AES_NUM_BYTES];
   aes_byte_t sb_in  [BYTES_PER_CYCLE];
   aes_byte_t sb_out [BYTES_PER_CYCLE];

   // Unpack the working word so byte selection uses a 4-bit byte index.
   always_comb begin
      for (int k = 0; k < AES_NUM_BYTES; k++) begin
         work_b[k] = work_q[AES_STATE_W-1-AES_BYTE_W*k -: AES_BYTE_W];
      end
   end

   always_comb begin
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         sb_in[j] = work_b[4'(int'(step_q) * BYTES_PER_CYCLE + j)];
      end
   end

   for (genvar j = 0; j < BYTES_PER_CYCLE; j++) begin : g_sbox
      inv_sbox u_inv_sbox (
         .sbox_in  (sb_in[j]),
         .sbox_out (sb_out[j])
      );
   end

   // Working word with the current step's bytes replaced in place.
   always_comb begin
      sub_b = work_b;
      for (int j = 0; j < BYTES_PER_CYCLE; j++) begin
         sub_b[4'(int'(step_q) * BYTES_PER_CYCLE + j)] = sb_out[j];
      end
      sub_state = '0;
      for (int k = 0; k < AES_NUM_BYTES; k++) begin
         sub_state[AES_STATE_W-1-AES_BYTE_W*k -: AES_BYTE_W] = sub_b[k];
      end
   end

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      work_d  = work_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d  = in_state;
               step_d  = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            work_d = sub_state;
            step_d = step_q + STEP_W'(1);
            if (step_q == LAST_STEP) begin
`ifdef INV_SUB_BYTES_SHIFT_EN
               // Row remap rides on the last write so DONE timing is unchanged.
               work_d = inv_shift_rows(sub_state);
`endif
               step_d  = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         step_q  <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         work_q  <= work_d;
      end
   end

   // out_state is only meaningful while out_valid; it reads 0 out of reset.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_state = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Self-checking bench for inv_sub_bytes_seq: BPC=4 main instance plus
// BPC 1/2/8/16 instances used for a full 256-value sweep.
module tb_inv_sub_bytes_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] in_state, out_state;

   inv_sub_bytes_seq #(.BYTES_PER_CYCLE(4)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   localparam int NSW = 4;
   logic         sw_in_valid  [NSW];
   logic         sw_in_ready  [NSW];
   logic [127:0] sw_in_state  [NSW];
   logic         sw_out_valid [NSW];
   logic         sw_out_ready [NSW];
   logic [127:0] sw_out_state [NSW];
   logic         sw_busy      [NSW];

   function automatic int bpc_of(input int g);
      return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
   endfunction

   for (genvar g = 0; g < NSW; g++) begin : g_sw
      localparam int P = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      inv_sub_bytes_seq #(.BYTES_PER_CYCLE(P)) u_sw (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (sw_in_valid[g]),
         .in_ready  (sw_in_ready[g]),
         .in_state  (sw_in_state[g]),
         .out_valid (sw_out_valid[g]),
         .out_ready (sw_out_ready[g]),
         .out_state (sw_out_state[g]),
         .busy      (sw_busy[g])
      );
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   // Inverse S-box derived from GF(2^8) arithmetic: S(x) = affine(x^-1), then inverted.
   logic [7:0] inv_tab [256];

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
         bb = {1'b0, bb[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   task automatic build_tables();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         inv_tab[s] = 8'(x);
      end
   endtask

   // Rows as a 4x4 matrix; row r is rotated right by r positions.
   function automatic logic [127:0] ref_shift(input logic [127:0] d);
      logic [7:0] m [4][4];
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            m[r][(c + r) % 4] = d[127-8*(r+4*c) -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = m[r][c];
      return o;
   endfunction

   function automatic logic [127:0] ref_model(input logic [127:0] d);
      logic [127:0] o;
      for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_tab[d[127-8*k -: 8]];
`ifdef INV_SUB_BYTES_SHIFT_EN
      o = ref_shift(o);
`endif
      return o;
   endfunction

   function automatic logic [127:0] adj(input logic [127:0] sub_only);
`ifdef INV_SUB_BYTES_SHIFT_EN
      return ref_shift(sub_only);
`else
      return sub_only;
`endif
   endfunction

   // ---------------- drivers ----------------
   task automatic run_main(input logic [127:0] din, output logic [127:0] dout, output int lat);
      @(negedge clk);
      chk("main_in_ready_idle", 128'(in_ready), 128'(1));
      in_state = din; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 64);
      dout = out_state;
      @(negedge clk);
      chk("main_post_hs_out_valid", 128'(out_valid), 128'(0));
   endtask

   task automatic run_sw(input int g, input logic [127:0] din, output logic [127:0] dout, output int lat);
      @(negedge clk);
      sw_in_state[g] = din; sw_in_valid[g] = 1'b1;
      @(posedge clk); #1;
      sw_in_valid[g] = 1'b0;
      sw_in_state[g] = {$urandom, $urandom, $urandom, $urandom};
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!sw_out_valid[g] && lat < 64);
      dout = sw_out_state[g];
      @(negedge clk);
   endtask

   typedef struct {
      logic [127:0] din;
      logic [127:0] dout;
   } vec_t;

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt [5];
      logic [127:0] dout, exp, din;
      int lat, seen;
      logic [7:0] mask;

      rst_n = 1'b0; in_valid = 1'b0; in_state = '0; out_ready = 1'b1;
      for (int g = 0; g < NSW; g++) begin
         sw_in_valid[g] = 1'b0; sw_in_state[g] = '0; sw_out_ready[g] = 1'b1;
      end
      build_tables();

      vt[0] = '{128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f};
      vt[1] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h52096ad53036a538bf40a39e81f3d7fb};
      vt[2] = '{{16{8'h63}}, {16{8'h00}}};
      vt[3] = '{{16{8'h00}}, {16{8'h52}}};
      vt[4] = '{{16{8'hff}}, {16{8'h7d}}};

      #23;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_out_state", out_state, 128'h0);
      @(negedge clk); rst_n = 1'b1;

      // Fixed vectors
      for (int i = 0; i < 5; i++) begin
         run_main(vt[i].din, dout, lat);
         chk($sformatf("vec%0d_out", i), dout, adj(vt[i].dout));
         chk($sformatf("vec%0d_lat", i), 128'(lat), 128'(5));
      end

`ifdef INV_SUB_BYTES_SHIFT_EN
      run_main(128'h637c777bf26b6fc53001672bfed7ab76, dout, lat);
      chk("shift_vec_out", dout, 128'h000d0a0704010e0b0805020f0c090603);
`endif

      // Back-pressure: stall 10 cycles in DONE while another word is offered
      din = 128'h00112233445566778899aabbccddeeff;
      exp = ref_model(din);
      @(negedge clk);
      in_state = din; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_state = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         chk("bp_in_ready_busy", 128'(in_ready), 128'(0));
      end while (!out_valid && lat < 64);
      chk("bp_lat", 128'(lat), 128'(5));
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_hold_valid", 128'(out_valid), 128'(1));
         chk("bp_hold_state", out_state, exp);
         chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
      end
      out_ready = 1'b1; in_valid = 1'b0;
      @(negedge clk);
      chk("bp_release_out_valid", 128'(out_valid), 128'(0));
      chk("bp_release_in_ready", 128'(in_ready), 128'(1));
      chk("bp_release_busy", 128'(busy), 128'(0));

      // Reset while BUSY at step 2
      @(negedge clk);
      in_state = {$urandom, $urandom, $urandom, $urandom}; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("midrst_busy_before", 128'(busy), 128'(1));
      rst_n = 1'b0; #1;
      chk("midrst_out_valid", 128'(out_valid), 128'(0));
      chk("midrst_in_ready", 128'(in_ready), 128'(1));
      chk("midrst_out_state", out_state, 128'h0);
      chk("midrst_busy", 128'(busy), 128'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("midrst_no_out_valid", 128'(seen), 128'(0));
      run_main(vt[1].din, dout, lat);
      chk("midrst_next_word", dout, adj(vt[1].dout));

      // Random words against the model
      for (int i = 0; i < 20; i++) begin
         din = {$urandom, $urandom, $urandom, $urandom};
         run_main(din, dout, lat);
         chk("rand_out", dout, ref_model(din));
         chk("rand_lat", 128'(lat), 128'(5));
      end

      // Sweep every byte value through each alternate BYTES_PER_CYCLE
      for (int g = 0; g < NSW; g++) begin
         mask = 8'($urandom_range(0, 255));
         for (int w = 0; w < 16; w++) begin
            for (int k = 0; k < 16; k++) din[127-8*k -: 8] = 8'(w * 16 + k) ^ mask;
            run_sw(g, din, dout, lat);
            chk($sformatf("sweep_bpc%0d_out", bpc_of(g)), dout, ref_model(din));
            chk($sformatf("sweep_bpc%0d_lat", bpc_of(g)), 128'(lat), 128'(16 / bpc_of(g) + 1));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/inv_sub_bytes_seq.md
Name: inv_sub_bytes_seq

Overview:
- Byte-serial AES InvSubBytes engine for the AES-256 decryption datapath; the inverse counterpart of the encryption-side S-box substitution.
- Accepts one 128-bit state word on a valid/ready handshake.
- Substitutes BYTES_PER_CYCLE bytes per clock through inverse S-box lookups, then presents the 128-bit result on a valid/ready output.
- Sits between the inverse-round key-add and InvMixColumns stages of the decryption round controller.

Parameters:
- BYTES_PER_CYCLE, 4, bytes substituted per clock. Legal values: 1, 2, 4, 8, 16. Any other value is a fatal elaboration error.
- NUM_STEPS, 16/BYTES_PER_CYCLE, derived localparam. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input state word valid
- in_ready  out  1  engine can accept a word
- in_state  in  128  state; byte s[k] = in_state[127-8k -: 8], column-major per FIPS-197 (s[r+4c] = row r, column c)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_state  out  128  substituted state, same byte ordering
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert handled upstream) forces the following. No X is ever driven on outputs.
  - state = IDLE, in_ready=1, out_valid=0, busy=0, out_state=0, step counter=0.
- FSM: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture in_state into the working register, clear the step counter, go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle, replace bytes s[step*BPC .. step*BPC+BPC-1] in place with InvSbox(byte) and increment step.
  - After step NUM_STEPS-1 is written, go to DONE.
- DONE:
  - out_valid=1; out_state holds the working register.
  - On out_valid&&out_ready: go to IDLE and deassert out_valid in the next cycle.
  - Without out_ready: hold out_valid and out_state stable indefinitely.
- Latency: accept edge to first out_valid cycle = NUM_STEPS+1 clocks (BPC=4: 5 clocks).
- Throughput: one word per NUM_STEPS+2 clocks with out_ready tied high.
- in_ready is strictly 0 in BUSY and DONE. An input offered then is not consumed and must be held by the sender.
- InvSbox is the exact FIPS-197 inverse table, so InvSbox(Sbox(x))==x for all 256 x. It is purely combinational, with BPC instances.
- Step counter width is $clog2(NUM_STEPS) with a minimum of 1 bit. For BPC=16, BUSY lasts exactly one cycle.
- Reset asserted mid-operation: the in-flight word is discarded and no out_valid is emitted for it.
- in_state changes after the accept edge have no effect.

Optional Feature:
- Macro: INV_SUB_BYTES_SHIFT_EN.
- Defined: the value captured in DONE applies InvShiftRows to the substituted state: out byte [r+4c] = sub byte [r+4((c-r) mod 4)].
  - Applied as a combinational remap on the capture path; latency is unchanged.
- Undefined: out_state is the pure InvSubBytes result and no remap logic exists.

Decomposition:
- Shared package aes_dec_pkg:
  - AES_STATE_W=128, AES_BYTE_W=8, AES_NUM_BYTES=16
  - typedef aes_state_t (logic [127:0]), typedef aes_byte_t
  - function inv_shift_rows(aes_state_t)
  - enum inv_sb_state_e {IDLE, BUSY, DONE}
- Sub-module inv_sbox (8-bit in, 8-bit out, combinational 256-entry case), instantiated BYTES_PER_CYCLE times.

Test Plan:
- BPC=4, macro off, in_state=0x637c777bf26b6fc53001672bfed7ab76, out_ready=1 -> out_state=0x000102030405060708090a0b0c0d0e0f, out_valid rises 5 clocks after accept.
- in_state=0x000102030405060708090a0b0c0d0e0f -> out_state=0x52096ad53036a538bf40a39e81f3d7fb; in_state all-0x63 -> all-0x00.
- Back-pressure: out_ready=0 for 10 cycles after DONE -> out_valid and out_state stable, in_ready=0 throughout; out_ready=1 -> handshake, IDLE next cycle.
- Reset mid-BUSY (rst_n low at step 2) -> out_valid=0, in_ready=1, out_state=0 immediately; the next word processes correctly.
- Sweep BPC in {1,2,8,16}, all 256 values (16 words, each value once) -> every byte equals the reference InvSbox, latency = NUM_STEPS+1.
- Macro on, in_state=0x637c777bf26b6fc53001672bfed7ab76 -> out_state=0x000d0a0704010e0b0805020f0c090603.
